// File: rtl/array_feed_pkg.sv
// Shared types and constants for the systolic-array ifm feeder.
package array_feed_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLR,
      LOAD,
      RUN,
      DRAIN
   } feed_state_e;

   localparam int unsigned HEIGHT_DEF = 32;
   localparam int unsigned DRAIN_CYC  = HEIGHT_DEF - 1;

   // Drain length for a given array height; at least one cycle so the counter is never empty.
   function automatic int unsigned drain_cyc(input int unsigned height);
      return (height > 1) ? height - 1 : 1;
   endfunction

endpackage

// File: rtl/array_ifm_feeder_skew_line.sv
// DEPTH-stage shift register with async reset; DEPTH=0 degenerates to a wire.
module skew_line #(
   parameter int unsigned DEPTH = 1,
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   if (DEPTH == 0) begin : g_wire
      // Clock and reset are intentionally unused in the zero-delay case.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign q = d;
   end else begin : g_reg
      logic [WIDTH-1:0] stage_q [DEPTH];

      // Shift the row-0 control/data bundle down the chain one stage per cycle.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
         end else begin
            stage_q[0] <= d;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
         end
      end

      assign q = stage_q[DEPTH-1];
   end

endmodule

// File: rtl/array_ifm_feeder.sv
// Row sequencer for the systolic array: holds each ifm vector for a programmable number of
// MAC cycles and drives per-row en/clr/mac_done/ifm with an h-cycle skew for row h.
module array_ifm_feeder import array_feed_pkg::*; #(
   parameter int unsigned HEIGHT = HEIGHT_DEF,
   parameter int unsigned IWIDTH = 16,
   parameter int unsigned CWIDTH = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic [CWIDTH-1:0]             cfg_mac_cyc,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [HEIGHT-1:0][IWIDTH-1:0] in_ifm,
   input  logic                          in_last,
   output logic                          busy,
   output logic                          done,
   output logic [HEIGHT-1:0]             en_i,
   output logic [HEIGHT-1:0]             clr_i,
   output logic [HEIGHT-1:0]             mac_done,
   output logic [HEIGHT-1:0][IWIDTH-1:0] ifm
);

   localparam int unsigned DRAIN_N = drain_cyc(HEIGHT);
   localparam int unsigned DW      = (DRAIN_N > 1) ? $clog2(DRAIN_N) : 1;
   localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_N - 1);

   feed_state_e                   state_q, state_d;
   logic [CWIDTH-1:0]             cnt_q, cnt_d;
   logic [CWIDTH-1:0]             mac_last_q, mac_last_d;
   logic [DW-1:0]                 dcnt_q, dcnt_d;
   logic [HEIGHT-1:0][IWIDTH-1:0] hold_q, hold_d;
   logic                          last_q, last_d;
   logic                          capture;
   logic                          en0_q, clr0_q, md0_q, done_q;

   // Next-state, counters, handshake and vector capture.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      mac_last_d = mac_last_q;
      dcnt_d     = dcnt_q;
      hold_d     = hold_q;
      last_d     = last_q;
      in_ready   = 1'b0;
      capture    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = CLR;
               // A zero cycle count is treated as one cycle per vector.
               mac_last_d = (cfg_mac_cyc == '0) ? '0 : cfg_mac_cyc - 1'b1;
               cnt_d      = '0;
               dcnt_d     = '0;
            end
         end
         CLR: state_d = LOAD;
         LOAD: begin
            in_ready = 1'b1;
            if (in_valid) begin
               capture = 1'b1;
               state_d = RUN;
               cnt_d   = '0;
            end
         end
         RUN: begin
            if (cnt_q != mac_last_q) begin
               cnt_d = cnt_q + 1'b1;
            end else if (last_q) begin
               state_d = DRAIN;
               dcnt_d  = '0;
            end else begin
               // Accept the next vector on the final cycle so back-to-back vectors have no bubble.
               in_ready = 1'b1;
               if (in_valid) begin
                  capture = 1'b1;
                  cnt_d   = '0;
               end else begin
                  state_d = LOAD;
               end
            end
         end
         DRAIN: begin
            if (dcnt_q == DRAIN_LAST) state_d = IDLE;
            else                      dcnt_d  = dcnt_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
      if (capture) begin
         hold_d = in_ifm;
         last_d = in_last;
      end
   end

   // FSM and datapath state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         mac_last_q <= '0;
         dcnt_q     <= '0;
         hold_q     <= '0;
         last_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         mac_last_q <= mac_last_d;
         dcnt_q     <= dcnt_d;
         hold_q     <= hold_d;
         last_q     <= last_d;
      end
   end

   // Row-0 controls as glitch-free flops; clr lands the cycle before the first enable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en0_q  <= 1'b0;
         clr0_q <= 1'b0;
         md0_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         en0_q  <= (state_d == RUN);
         md0_q  <= (state_d == RUN) && (cnt_d == mac_last_q);
         clr0_q <= (state_q == CLR);
         done_q <= (state_q == DRAIN) && (dcnt_q == DRAIN_LAST);
      end
   end

   assign busy = (state_q != IDLE);
   assign done = done_q;

   for (genvar h = 0; h < HEIGHT; h++) begin : g_row
      logic [IWIDTH+2:0] row_d, row_q;

      // ifm rides along with the controls, so it simply holds whenever en is low.
      assign row_d = {clr0_q, en0_q, md0_q, hold_q[h]};

      skew_line #(
         .DEPTH(h),
         .WIDTH(IWIDTH + 3)
      ) u_skew (
         .clk  (clk),
         .rst_n(rst_n),
         .d    (row_d),
         .q    (row_q)
      );

      assign clr_i[h]    = row_q[IWIDTH+2];
      assign en_i[h]     = row_q[IWIDTH+1];
      assign mac_done[h] = row_q[IWIDTH];
      assign ifm[h]      = row_q[IWIDTH-1:0];
   end

endmodule

// File: tb/tb_array_ifm_feeder.sv
// Directed bench for array_ifm_feeder. Time t counts clock edges from the edge that samples
// start (t=0); all outputs are sampled 1 ns after edge t. Expected row-h waveforms are the
// row-0 waveforms from the hand-written tables delayed by h.
module tb_array_ifm_feeder;

   localparam int unsigned HEIGHT = 32;
   localparam int unsigned IWIDTH = 16;
   localparam int unsigned CWIDTH = 8;
   localparam int unsigned VW     = HEIGHT * IWIDTH;
   localparam int          TMAX   = 64;

   logic                          clk = 1'b0;
   logic                          rst_n;
   logic                          start;
   logic [CWIDTH-1:0]             cfg_mac_cyc;
   logic                          in_valid;
   logic                          in_ready;
   logic [HEIGHT-1:0][IWIDTH-1:0] in_ifm;
   logic                          in_last;
   logic                          busy;
   logic                          done;
   logic [HEIGHT-1:0]             en_i;
   logic [HEIGHT-1:0]             clr_i;
   logic [HEIGHT-1:0]             mac_done;
   logic [HEIGHT-1:0][IWIDTH-1:0] ifm;

   array_ifm_feeder #(
      .HEIGHT(HEIGHT),
      .IWIDTH(IWIDTH),
      .CWIDTH(CWIDTH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .cfg_mac_cyc(cfg_mac_cyc),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_ifm     (in_ifm),
      .in_last    (in_last),
      .busy       (busy),
      .done       (done),
      .en_i       (en_i),
      .clr_i      (clr_i),
      .mac_done   (mac_done),
      .ifm        (ifm)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int done_cnt;

   // Row-0 expectations indexed by t.
   bit                en_r0  [TMAX];
   bit                clr_r0 [TMAX];
   bit                md_r0  [TMAX];
   bit                rdy_m  [TMAX];
   logic [IWIDTH-1:0] ifm0_m [TMAX];
   int                done_at;
   int                busy_last;

   task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear;
      for (int i = 0; i < TMAX; i++) begin
         en_r0[i]  = 1'b0;
         clr_r0[i] = 1'b0;
         md_r0[i]  = 1'b0;
         rdy_m[i]  = 1'b0;
         ifm0_m[i] = '0;
      end
      done_at   = -1;
      busy_last = -1;
      done_cnt  = 0;
   endtask

   // Lane h of vector k is k*0x100 + h + 1.
   function automatic logic [HEIGHT-1:0][IWIDTH-1:0] mkvec(input int k);
      logic [HEIGHT-1:0][IWIDTH-1:0] v;
      for (int h = 0; h < HEIGHT; h++) v[h] = IWIDTH'(k * 256 + h + 1);
      return v;
   endfunction

   task automatic cyc(input string tag, input int t);
      logic [HEIGHT-1:0] e, c, m;
      for (int h = 0; h < HEIGHT; h++) begin
         e[h] = (t - h >= 0) ? en_r0[t-h]  : 1'b0;
         c[h] = (t - h >= 0) ? clr_r0[t-h] : 1'b0;
         m[h] = (t - h >= 0) ? md_r0[t-h]  : 1'b0;
      end
      chk($sformatf("%s.en@%0d", tag, t), en_i, e);
      chk($sformatf("%s.clr@%0d", tag, t), clr_i, c);
      chk($sformatf("%s.mac_done@%0d", tag, t), mac_done, m);
      chk($sformatf("%s.done@%0d", tag, t), done, (t == done_at));
      chk($sformatf("%s.busy@%0d", tag, t), busy, (t <= busy_last));
      chk($sformatf("%s.in_ready@%0d", tag, t), in_ready, rdy_m[t]);
      chk($sformatf("%s.ifm0@%0d", tag, t), ifm[0], ifm0_m[t]);
      if (done) done_cnt++;
   endtask

   initial begin
      logic [HEIGHT-1:0][IWIDTH-1:0] exp_v;
      logic [HEIGHT-1:0][IWIDTH-1:0] junk;
      for (int h = 0; h < HEIGHT; h++) junk[h] = 16'hDEAD;

      // Reset state.
      rst_n = 1'b0; start = 1'b0; cfg_mac_cyc = '0;
      in_valid = 1'b0; in_ifm = '0; in_last = 1'b0;
      repeat (3) tick;
      chk("rst.en", en_i, '0);
      chk("rst.clr", clr_i, '0);
      chk("rst.mac_done", mac_done, '0);
      chk("rst.ifm", ifm, '0);
      chk("rst.busy", busy, 1'b0);
      chk("rst.done", done, 1'b0);
      chk("rst.in_ready", in_ready, 1'b0);
      rst_n = 1'b1;
      tick;

      // Reset mid-RUN with row 5 enabled.
      model_clear;
      clr_r0[1] = 1'b1;
      for (int i = 2; i <= 5; i++) en_r0[i] = 1'b1;
      md_r0[5] = 1'b1;
      rdy_m[1] = 1'b1;
      busy_last = TMAX;
      for (int i = 2; i < TMAX; i++) ifm0_m[i] = 16'h0501;
      cfg_mac_cyc = 8'd4; in_ifm = mkvec(5); in_last = 1'b1;
      for (int t = 0; t <= 8; t++) begin
         start = (t == 0); in_valid = (t <= 2);
         tick;
         cyc("rstrun", t);
      end
      #2 rst_n = 1'b0;
      #1;
      chk("rstrun.en", en_i, '0);
      chk("rstrun.clr", clr_i, '0);
      chk("rstrun.mac_done", mac_done, '0);
      chk("rstrun.ifm", ifm, '0);
      chk("rstrun.busy", busy, 1'b0);
      chk("rstrun.done", done, 1'b0);
      chk("rstrun.in_ready", in_ready, 1'b0);
      tick;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick;
         chk("rstrun.post_done", done, 1'b0);
         chk("rstrun.post_busy", busy, 1'b0);
      end

      // in_valid in IDLE is not taken.
      model_clear;
      cfg_mac_cyc = 8'd4; in_ifm = mkvec(0); in_last = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("idle.in_ready", in_ready, 1'b0);
         chk("idle.busy", busy, 1'b0);
         chk("idle.ifm", ifm, '0);
      end

      // Single vector, cfg=4, full wavefront and drain.
      clr_r0[1] = 1'b1;
      for (int i = 2; i <= 5; i++) en_r0[i] = 1'b1;
      md_r0[5] = 1'b1;
      rdy_m[1] = 1'b1;
      done_at = 37; busy_last = 36;
      for (int i = 2; i < TMAX; i++) ifm0_m[i] = 16'h0001;
      for (int t = 0; t <= 45; t++) begin
         start = (t == 0); in_valid = (t <= 2);
         tick;
         cyc("single", t);
         if (t == 17) begin
            for (int h = 0; h < HEIGHT; h++) exp_v[h] = (h <= 15) ? mkvec(0)[h] : '0;
            chk("single.ifm_front@17", ifm, exp_v);
         end
      end
      chk("single.done_count", done_cnt, 1);
      chk("single.ifm_final", ifm, mkvec(0));

      // cfg=0 behaves as 1; three back-to-back vectors.
      model_clear;
      clr_r0[1] = 1'b1;
      for (int i = 2; i <= 4; i++) begin
         en_r0[i] = 1'b1;
         md_r0[i] = 1'b1;
      end
      for (int i = 1; i <= 3; i++) rdy_m[i] = 1'b1;
      done_at = 36; busy_last = 35;
      ifm0_m[0] = 16'h0001; ifm0_m[1] = 16'h0001;
      ifm0_m[2] = 16'h0101; ifm0_m[3] = 16'h0201;
      for (int i = 4; i < TMAX; i++) ifm0_m[i] = 16'h0301;
      cfg_mac_cyc = 8'd0;
      for (int t = 0; t <= 40; t++) begin
         start = (t == 0); in_valid = (t <= 4); in_last = (t >= 4);
         in_ifm = (t <= 2) ? mkvec(1) : (t == 3) ? mkvec(2) : mkvec(3);
         tick;
         cyc("b2b", t);
      end
      chk("b2b.done_count", done_cnt, 1);
      chk("b2b.ifm_final", ifm, mkvec(3));

      // cfg=3 with a two-cycle valid gap between vectors.
      model_clear;
      clr_r0[1] = 1'b1;
      for (int i = 2; i <= 4; i++) en_r0[i] = 1'b1;
      for (int i = 7; i <= 9; i++) en_r0[i] = 1'b1;
      md_r0[4] = 1'b1; md_r0[9] = 1'b1;
      rdy_m[1] = 1'b1; rdy_m[4] = 1'b1; rdy_m[5] = 1'b1; rdy_m[6] = 1'b1;
      done_at = 41; busy_last = 40;
      ifm0_m[0] = 16'h0301; ifm0_m[1] = 16'h0301;
      for (int i = 2; i <= 6; i++) ifm0_m[i] = 16'h0401;
      for (int i = 7; i < TMAX; i++) ifm0_m[i] = 16'h0601;
      cfg_mac_cyc = 8'd3;
      for (int t = 0; t <= 45; t++) begin
         start = (t == 0);
         if (t <= 2) begin
            in_valid = 1'b1; in_ifm = mkvec(4); in_last = 1'b0;
         end else if (t <= 6) begin
            in_valid = 1'b0; in_ifm = junk; in_last = 1'b1;
         end else begin
            in_valid = (t == 7); in_ifm = mkvec(6); in_last = 1'b1;
         end
         tick;
         cyc("gap", t);
      end
      chk("gap.done_count", done_cnt, 1);
      chk("gap.ifm_final", ifm, mkvec(6));

      // start re-pulsed while busy and cfg changed mid-job.
      model_clear;
      clr_r0[1] = 1'b1;
      en_r0[2] = 1'b1; en_r0[3] = 1'b1;
      md_r0[3] = 1'b1;
      rdy_m[1] = 1'b1;
      done_at = 35; busy_last = 34;
      ifm0_m[0] = 16'h0601; ifm0_m[1] = 16'h0601;
      for (int i = 2; i < TMAX; i++) ifm0_m[i] = 16'h0701;
      in_ifm = mkvec(7); in_last = 1'b1;
      for (int t = 0; t <= 40; t++) begin
         start = (t == 0) || (t == 3) || (t == 4) || (t == 10) || (t == 20);
         cfg_mac_cyc = (t == 0) ? 8'd2 : 8'd7;
         in_valid = (t <= 2);
         tick;
         cyc("busystart", t);
      end
      chk("busystart.done_count", done_cnt, 1);
      start = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
